// File: rtl/ovi_store_streamer.sv
// ovi_store_streamer: buffers VPU store lines and streams them to the
// core memory port as addressed, byte-enabled packets.
// Ports:
//   CLK, RST                     clock, async active-high reset
//   START/_ADDR/_VL/_SEW         operation start pulse and descriptor
//   KILL                         abort; BUSY high outside IDLE
//   STORE_VALID/_DATA            VPU store lines (credit controlled)
//   STORE_CREDIT                 one pulse per drained line
//   MEM_VALID/_READY/_ADDR/_DATA/_BYEN  packet handshake to core
//   SYNC_END                     end-of-operation pulse
//   OVERFLOW                     sticky dropped-line flag
module ovi_store_streamer #(
  parameter int MEMDATA_W = 512,
  parameter int PKT_W     = 64,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 32,
  parameter int VL_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [ADDR_W-1:0]    START_ADDR,
  input  logic [VL_W-1:0]      START_VL,
  input  logic [1:0]           START_SEW,
  input  logic                 KILL,
  output logic                 BUSY,
  input  logic                 STORE_VALID,
  input  logic [MEMDATA_W-1:0] STORE_DATA,
  output logic                 STORE_CREDIT,
  output logic                 MEM_VALID,
  input  logic                 MEM_READY,
  output logic [ADDR_W-1:0]    MEM_ADDR,
  output logic [PKT_W-1:0]     MEM_DATA,
  output logic [PKT_W/8-1:0]   MEM_BYEN,
  output logic                 SYNC_END,
  output logic                 OVERFLOW
);

  localparam int PB     = PKT_W / 8;
  localparam int LB     = MEMDATA_W / 8;
  localparam int P      = MEMDATA_W / PKT_W;
  localparam int LOG_PB = $clog2(PB);
  localparam int LOG_LB = $clog2(LB);
  localparam int TB_W   = VL_W + 3;
  localparam int CW     = TB_W + 1;
  localparam int KW     = (P > 1) ? $clog2(P) : 1;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW     = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [MEMDATA_W-1:0] buf_q [DEPTH];
  logic [PW-1:0]        head_q, tail_q;
  logic [NW-1:0]        cnt_q;
  logic [ADDR_W-1:0]    base_q, off_q;
  logic [TB_W-1:0]      tb_q;
  logic [CW-1:0]        np_q, nl_q;
  logic [CW-1:0]        sent_q, lines_q;
  logic [KW-1:0]        pk_q;
  logic                 credit_q, sync_q, ovf_q;

  logic [TB_W-1:0] tb_d;
  logic [CW-1:0]   np_d, nl_d;
  logic            take, hs, last, pop, push;
  logic            ovf_set, sync_d;
  logic [PB-1:0]   byen;
  int              rem;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign tb_d = TB_W'(START_VL) << START_SEW;
  assign np_d = CW'(({1'b0, tb_d} + CW'(PB - 1)) >> LOG_PB);
  assign nl_d = CW'(({1'b0, tb_d} + CW'(LB - 1)) >> LOG_LB);

  assign take = (state_q == IDLE) && START && !KILL;
  assign MEM_VALID = (state_q == STREAM) && (cnt_q != '0);
  assign hs   = MEM_VALID && MEM_READY;
  assign last = (sent_q == np_q - CW'(1));
  assign pop  = hs && ((pk_q == KW'(P - 1)) || last);

  // A pop in the same cycle frees the head slot, so a full buffer
  // can still take a new line.
  assign push = STORE_VALID && !KILL
             && (state_q == STREAM)
             && (lines_q < nl_q)
             && ((cnt_q != NW'(DEPTH)) || pop);

  assign ovf_set = STORE_VALID && !push && !KILL;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (START)
          state_d = (tb_d == '0) ? DONE : STREAM;
      end
      STREAM: begin
        if (hs && last)
          state_d = DONE;
      end
      DONE: begin
        if (sync_q)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (KILL)
      state_d = IDLE;
  end

  // SYNC_END follows the final handshake directly; a zero-length
  // operation spends one extra DONE cycle before its pulse.
  always_comb begin
    sync_d = 1'b0;
    if (!KILL) begin
      if ((state_q == STREAM) && hs && last)
        sync_d = 1'b1;
      else if ((state_q == DONE) && !sync_q)
        sync_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      base_q   <= '0;
      off_q    <= '0;
      tb_q     <= '0;
      np_q     <= '0;
      nl_q     <= '0;
      sent_q   <= '0;
      lines_q  <= '0;
      pk_q     <= '0;
      credit_q <= 1'b0;
      sync_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      credit_q <= pop && !KILL;
      ovf_q    <= ovf_set || (ovf_q && !take);
      if (KILL) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else if (take) begin
        base_q  <= START_ADDR;
        tb_q    <= tb_d;
        np_q    <= np_d;
        nl_q    <= nl_d;
        off_q   <= '0;
        sent_q  <= '0;
        lines_q <= '0;
        pk_q    <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        cnt_q   <= '0;
      end else begin
        if (push) begin
          tail_q  <= nxt(tail_q);
          lines_q <= lines_q + CW'(1);
        end
        if (pop)
          head_q <= nxt(head_q);
        cnt_q <= cnt_q + NW'(push) - NW'(pop);
        if (hs) begin
          sent_q <= sent_q + CW'(1);
          off_q  <= off_q + ADDR_W'(PB);
          pk_q   <= pop ? '0 : pk_q + KW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      buf_q[tail_q] <= STORE_DATA;
  end

  assign rem = int'(tb_q & TB_W'(PB - 1));

  always_comb begin
    byen = '0;
    if (MEM_VALID) begin
      for (int i = 0; i < PB; i++)
        byen[i] = !(last && (rem != 0)) || (i < rem);
    end
  end

  assign MEM_ADDR = MEM_VALID ? base_q + off_q : '0;
  assign MEM_DATA = MEM_VALID
                  ? buf_q[head_q][pk_q * PKT_W +: PKT_W]
                  : '0;
  assign MEM_BYEN     = byen;
  assign BUSY         = (state_q != IDLE);
  assign STORE_CREDIT = credit_q;
  assign SYNC_END     = sync_q;
  assign OVERFLOW     = ovf_q;

endmodule
